// File: rtl/cenn_pkg.sv
// Shared types for the CeNN feedback buffer: controller states and the stored pixel pair.
package cenn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int pixel_width = 15;

   typedef struct packed {
      logic [pixel_width-1:0] y;
      logic [pixel_width-1:0] x;
   } pixel_pair_t;

endpackage

// File: rtl/cenn_feedback_buffer_if.sv
// Control, collect-stream and emit-stream signals between the processing element side and the buffer.
interface cenn_feedback_buffer_if #(
   parameter int width     = 15,
   parameter int iter_bits = 8
);
   logic                 start;
   logic [iter_bits-1:0] n_iter;
   logic                 in_valid;
   logic [width-1:0]     in_y;
   logic [width-1:0]     in_x;
   logic                 ready_fixed;
   logic [width-1:0]     pixel_y;
   logic [width-1:0]     pixel_x;
   logic                 busy;
   logic                 done;
   logic [iter_bits-1:0] iter_count;
   logic                 err;

   modport master (
      output start, n_iter, in_valid, in_y, in_x,
      input  ready_fixed, pixel_y, pixel_x, busy, done, iter_count, err
   );

   modport slave (
      input  start, n_iter, in_valid, in_y, in_x,
      output ready_fixed, pixel_y, pixel_x, busy, done, iter_count, err
   );
endinterface

// File: rtl/cenn_bank_ram.sv
// Two-bank frame store: one write port, one registered read port (old data on same-address collision).
module cenn_bank_ram #(
   parameter int width      = 15,
   parameter int frame_size = 100,
   parameter int addr_bits  = $clog2(frame_size)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic                 wr_bank,
   input  logic [addr_bits-1:0] wr_addr,
   input  logic [2*width-1:0]   wr_data,
   input  logic                 rd_en,
   input  logic                 rd_bank,
   input  logic [addr_bits-1:0] rd_addr,
   output logic [2*width-1:0]   rd_data
);
   localparam int depth    = 2 * frame_size;
   localparam int idx_bits = $clog2(depth);

   logic [2*width-1:0]  mem [depth];
   logic [idx_bits-1:0] wr_idx;
   logic [idx_bits-1:0] rd_idx;

   // Logical address is {bank, addr}; bank 1 is packed right after bank 0 so odd frame sizes waste nothing.
   function automatic logic [idx_bits-1:0] to_idx(input logic bank, input logic [addr_bits-1:0] addr);
      return bank ? idx_bits'(frame_size) + idx_bits'(addr) : idx_bits'(addr);
   endfunction

   assign wr_idx = to_idx(wr_bank, wr_addr);
   assign rd_idx = to_idx(rd_bank, rd_addr);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_idx];
   end

endmodule

// File: rtl/cenn_feedback_buffer.sv
// Euler-loop feedback buffer: collects PE output frames and re-streams them as pixel_y/pixel_x for n_iter iterations.
//   state | meaning
//   IDLE  | waiting for start; in_valid flags err
//   LOAD  | writing initial frame {y0,x0} into bank 0
//   RUN   | emitting bank rd_bank while collecting into the other bank
//   DONE  | all iterations finished; in_valid flags err, start restarts
module cenn_feedback_buffer
   import cenn_pkg::*;
#(
   parameter int width         = 15,
   parameter int length_column = 10,
   parameter int length_row    = 10,
   parameter int iter_bits     = 8
) (
   input logic                   clk,
   input logic                   rst,
   cenn_feedback_buffer_if.slave bus
);
   localparam int frame_size = length_column * length_row;
   localparam int aw         = $clog2(frame_size + 1);
   localparam int ram_aw     = $clog2(frame_size);
   localparam logic [aw-1:0] full_addr = aw'(frame_size);
   localparam logic [aw-1:0] last_addr = aw'(frame_size - 1);

   state_t               state, state_nx;
   logic [iter_bits-1:0] n_iter_q, iter_count_q;
   logic [aw-1:0]        wr_addr, rd_addr;
   logic                 rd_bank, err_q, done_q, ready_q;
   logic                 busy, wr_en, wr_bank, rd_issue, in_reject;
   logic                 start_ok, emit_done, collect_done, wr_last, frame_end, last_iter;
   logic [2*width-1:0]   rd_word;

   assign start_ok     = bus.start && (state == IDLE || state == DONE);
   assign emit_done    = (rd_addr == full_addr);
   assign collect_done = (wr_addr == full_addr);
   assign wr_last      = wr_en && (wr_addr == last_addr);
   // The word completing the collect frame counts toward this cycle's end test.
   assign frame_end    = (state == RUN) && emit_done && (collect_done || wr_last);
   assign last_iter    = (iter_count_q + iter_bits'(1)) == n_iter_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE, DONE: if (start_ok) state_nx = LOAD;
         LOAD:       if (wr_last)  state_nx = (n_iter_q == '0) ? DONE : RUN;
         RUN:        if (frame_end && last_iter) state_nx = DONE;
         default:    state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      wr_en     = 1'b0;
      wr_bank   = 1'b0;
      rd_issue  = 1'b0;
      in_reject = 1'b0;
      unique case (state)
         LOAD: begin
            busy  = 1'b1;
            wr_en = bus.in_valid;
         end
         RUN: begin
            busy      = 1'b1;
            rd_issue  = !emit_done;
            wr_en     = bus.in_valid && !collect_done;
            wr_bank   = ~rd_bank;
            in_reject = bus.in_valid && collect_done;
         end
         default: in_reject = bus.in_valid;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_iter_q     <= '0;
         iter_count_q <= '0;
         wr_addr      <= '0;
         rd_addr      <= '0;
         rd_bank      <= 1'b0;
         err_q        <= 1'b0;
         done_q       <= 1'b0;
         ready_q      <= 1'b0;
      end else begin
         done_q  <= (state_nx == DONE) && (state != DONE);
         ready_q <= rd_issue;
         if (start_ok)       err_q <= 1'b0;
         else if (in_reject) err_q <= 1'b1;

         if (start_ok) begin
            n_iter_q     <= bus.n_iter;
            iter_count_q <= '0;
            wr_addr      <= '0;
            rd_addr      <= '0;
            rd_bank      <= 1'b0;
         end else if (state == LOAD) begin
            if (wr_en) wr_addr <= wr_last ? '0 : wr_addr + aw'(1);
         end else if (state == RUN) begin
            if (frame_end) begin
               iter_count_q <= iter_count_q + iter_bits'(1);
               rd_bank      <= ~rd_bank;
               wr_addr      <= '0;
               rd_addr      <= '0;
            end else begin
               if (wr_en)    wr_addr <= wr_addr + aw'(1);
               if (rd_issue) rd_addr <= rd_addr + aw'(1);
            end
         end
      end
   end

   cenn_bank_ram #(
      .width      (width),
      .frame_size (frame_size),
      .addr_bits  (ram_aw)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_bank (wr_bank),
      .wr_addr (wr_addr[ram_aw-1:0]),
      .wr_data ({bus.in_y, bus.in_x}),
      .rd_en   (rd_issue),
      .rd_bank (rd_bank),
      .rd_addr (rd_addr[ram_aw-1:0]),
      .rd_data (rd_word)
   );

   assign bus.ready_fixed = ready_q;
   assign bus.pixel_y     = rd_word[2*width-1:width];
   assign bus.pixel_x     = rd_word[width-1:0];
   assign bus.busy        = busy;
   assign bus.done        = done_q;
   assign bus.iter_count  = iter_count_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_cenn_feedback_buffer.sv
// Scoreboard bench for cenn_feedback_buffer with a 4x2 frame: expected pixels are queued at stimulus time.
module tb_cenn_feedback_buffer;
   import cenn_pkg::*;

   localparam int fs = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cenn_feedback_buffer_if #(.width(15), .iter_bits(8)) bus ();

   cenn_feedback_buffer #(
      .width         (15),
      .length_column (4),
      .length_row    (2),
      .iter_bits     (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks    = 0;
   int errors    = 0;
   int ready_cnt = 0;
   int done_cnt  = 0;
   int run_len   = 0;
   int r0;
   pixel_pair_t exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send(input logic [14:0] y, input logic [14:0] x, input int gap);
      bus.in_valid = 1'b1;
      bus.in_y     = y;
      bus.in_x     = x;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_frame(input int by, input int bx, input int gap);
      for (int i = 0; i < fs; i++) send(15'(by + i), 15'(bx + i), (i == fs - 1) ? 0 : gap);
   endtask

   task automatic push_frame(input int by, input int bx);
      pixel_pair_t p;
      for (int i = 0; i < fs; i++) begin
         p.y = 15'(by + i);
         p.x = 15'(bx + i);
         exp_q.push_back(p);
      end
   endtask

   task automatic do_start(input int n);
      bus.start  = 1'b1;
      bus.n_iter = 8'(n);
      @(negedge clk);
      bus.start  = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.done) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s_done: done not seen within 200 cycles", name);
      end else begin
         @(negedge clk);
         check({name, "_done_pulse_width"}, int'(bus.done), 0);
      end
   endtask

   task automatic wait_iter(input int target, input string name);
      bit got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (int'(bus.iter_count) == target) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s: iter_count=%0d, expected %0d within 200 cycles", name, bus.iter_count, target);
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_ready"},  int'(bus.ready_fixed), 0);
      check({name, "_pixel_y"}, int'(bus.pixel_y), 0);
      check({name, "_pixel_x"}, int'(bus.pixel_x), 0);
      check({name, "_busy"},   int'(bus.busy), 0);
      check({name, "_done"},   int'(bus.done), 0);
      check({name, "_iter"},   int'(bus.iter_count), 0);
      check({name, "_err"},    int'(bus.err), 0);
   endtask

   // Monitor: pops one expected pixel per ready_fixed and checks each emission burst is one whole frame.
   initial begin
      pixel_pair_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            run_len = 0;
            continue;
         end
         if (bus.done) done_cnt++;
         if (bus.ready_fixed) begin
            ready_cnt++;
            run_len++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pixel: got y=%0d x=%0d, expected no emission", bus.pixel_y, bus.pixel_x);
            end else begin
               e = exp_q.pop_front();
               if (bus.pixel_y !== e.y || bus.pixel_x !== e.x) begin
                  errors++;
                  $display("FAIL pixel: got y=%0d x=%0d expected y=%0d x=%0d", bus.pixel_y, bus.pixel_x, e.y, e.x);
               end
            end
         end else if (run_len != 0) begin
            checks++;
            if (run_len != fs) begin
               errors++;
               $display("FAIL emit_run_length: got %0d expected %0d", run_len, fs);
            end
            run_len = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start    = 1'b0;
      bus.n_iter   = '0;
      bus.in_valid = 1'b0;
      bus.in_y     = '0;
      bus.in_x     = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // single iteration
      r0 = ready_cnt;
      do_start(1);
      push_frame(100, 0);
      send_frame(100, 0, 0);
      send_frame(500, 200, 0);
      wait_done("single");
      check("single_iter", int'(bus.iter_count), 1);
      check("single_busy", int'(bus.busy), 0);
      check("single_err", int'(bus.err), 0);
      check("single_ready_count", ready_cnt - r0, fs);
      send(1, 1, 0);
      check("done_in_valid_err", int'(bus.err), 1);

      // ping-pong, three iterations
      r0 = ready_cnt;
      do_start(3);
      check("start_clears_err", int'(bus.err), 0);
      push_frame(100, 0);
      send_frame(100, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         if (k < 3) push_frame(100 + 1000 * k, 1000 * k);
         send_frame(100 + 1000 * k, 1000 * k, 0);
         if (k < 3) wait_iter(k, "pingpong_iter");
      end
      wait_done("pingpong");
      check("pingpong_iter_final", int'(bus.iter_count), 3);
      check("pingpong_ready_count", ready_cnt - r0, 3 * fs);

      // skewed, gapped collection
      do_start(2);
      push_frame(300, 40);
      send_frame(300, 40, 0);
      repeat (4) @(negedge clk);
      push_frame(700, 60);
      send_frame(700, 60, 3);
      check("skew_gap_ready", int'(bus.ready_fixed), 0);
      check("skew_hold_pixel_y", int'(bus.pixel_y), 307);
      check("skew_hold_pixel_x", int'(bus.pixel_x), 47);
      @(negedge clk);
      check("skew_next_emit", int'(bus.ready_fixed), 1);
      send_frame(900, 80, 0);
      wait_done("skew");
      check("skew_iter_final", int'(bus.iter_count), 2);

      // overflow: ninth collect word is dropped
      do_start(2);
      push_frame(20, 10);
      send_frame(20, 10, 0);
      push_frame(600, 300);
      send_frame(600, 300, 0);
      send(999, 999, 0);
      check("overflow_err", int'(bus.err), 1);
      check("overflow_iter", int'(bus.iter_count), 1);
      send_frame(50, 50, 0);
      wait_done("overflow");
      check("overflow_err_sticky", int'(bus.err), 1);
      check("overflow_iter_final", int'(bus.iter_count), 2);

      // reset mid-RUN, then a clean single iteration
      do_start(2);
      push_frame(40, 30);
      send_frame(40, 30, 0);
      send(1, 2, 0);
      send(3, 4, 0);
      #2 rst = 1'b1;
      #1 check_all_zero("midrun_reset");
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      do_start(1);
      push_frame(111, 222);
      send_frame(111, 222, 0);
      send_frame(5, 6, 0);
      wait_done("after_reset");
      check("after_reset_iter", int'(bus.iter_count), 1);

      // idle in_valid, then n_iter = 0
      #2 rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      send(7, 7, 0);
      check("idle_err", int'(bus.err), 1);
      check("idle_busy", int'(bus.busy), 0);
      r0 = ready_cnt;
      do_start(0);
      check("zero_start_clears_err", int'(bus.err), 0);
      check("zero_busy_load", int'(bus.busy), 1);
      send_frame(1, 1, 0);
      wait_done("zero_iter");
      check("zero_iter_count", int'(bus.iter_count), 0);
      check("zero_ready_count", ready_cnt - r0, 0);
      check("zero_busy_done", int'(bus.busy), 0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      check("done_pulses", done_cnt, 6);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
